uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//   UART 8N1 receiver, the receive-side counterpart of the UART transmitter (data/send/ready/TX).
//   Samples serial line RX at mid-bit, assembles an LSB-first byte, and presents it with a
//   one-cycle valid strobe. Flags framing errors.
//   Sits between the board-level RX pin and the byte-level consumer.
//   Default timing: 50 MHz clk, 9600 bps.
// PARAMETERS
//   CLKS_PER_BIT  5208  clk cycles per bit (50_000_000/9600); must be >= 4
//   SYNC_STAGES   2     flip-flops in the RX metastability synchronizer (>= 2)
// PORTS
//   clk           in   1  system clock, all logic on posedge
//   reset_n       in   1  asynchronous active-low reset
//   RX            in   1  serial input; idle high, asynchronous to clk
//   rx_data       out  8  last correctly received byte; held until next good byte
//   rx_valid      out  1  1-cycle pulse: rx_data updated this cycle
//   rx_frame_err  out  1  1-cycle pulse: stop bit sampled low
//   rx_busy       out  1  high from start-edge detection until return to IDLE
// BEHAVIOUR
//   Reset (async, reset_n=0)
//   - rx_data=8'h00; rx_valid, rx_frame_err, rx_busy = 0.
//   - Synchronizer preset to 1 (idle); state=IDLE; counters=0.
//   - Reset mid-frame aborts the frame; no strobe is issued.
//   Synchronized line rxs = RX after SYNC_STAGES flops. All decisions use rxs only.
//   Counters
//   - baud_cnt width $clog2(CLKS_PER_BIT). Terminal count = CLKS_PER_BIT-1, then wraps to 0.
//   - bit_idx is 3 bits.
//   FSM states and transitions
//   - IDLE: on rxs==0, go to START with baud_cnt=0 and rx_busy=1.
//   - START: count to HALF=(CLKS_PER_BIT/2)-1.
//     - If rxs==1 at HALF: false start; go to IDLE, no strobe.
//     - If rxs==0 at HALF: baud_cnt=0, bit_idx=0, go to DATA.
//   - DATA: at each baud_cnt==CLKS_PER_BIT-1 (mid-bit), shift rxs into shreg[bit_idx] (LSB first).
//     - After bit_idx==7, go to STOP.
//   - STOP: at baud_cnt==CLKS_PER_BIT-1:
//     - rxs==1: rx_data<=shreg, rx_valid=1 for the next cycle, go to IDLE.
//     - rxs==0: rx_frame_err=1 for the next cycle, rx_data unchanged, go to BREAK.
//   - BREAK: wait for rxs==1 (line held low / break), then go to IDLE.
//   - rx_busy=0 only in IDLE.
//   Latency
//   - rx_valid rises 9*CLKS_PER_BIT + HALF + 1 cycles after the first cycle rxs==0,
//     plus SYNC_STAGES from the RX pin.
//   Back-to-back frames
//   - Return to IDLE happens at mid-stop-bit, so a start bit immediately following the stop
//     bit (zero idle gap) is detected.
//   - rx_valid and rx_frame_err are never both high in the same cycle.
//   No flow control: the consumer must capture rx_data on rx_valid. A later good byte
//   overwrites rx_data.
// TESTING  (CLKS_PER_BIT=16 unless noted; bench drives RX per 16-cycle bit)
//   1. Frame 0xA5, stop=1
//      -> rx_valid pulses exactly once for 1 cycle with rx_data=8'hA5.
//      -> rx_busy high throughout the frame, low after.
//   2. RX low for 5 cycles, then high (glitch < HALF=7)
//      -> no rx_valid, no rx_frame_err; rx_busy returns to 0; rx_data unchanged.
//   3. Frame 0x3C with stop=0, line held low 40 cycles, then high
//      -> one rx_frame_err pulse; rx_data stays at previous value.
//      -> no new frame starts until RX goes high.
//      -> a following 0x81 frame is received correctly.
//   4. Frames 0x00 then 0xFF with zero idle gap
//      -> two rx_valid pulses, rx_data 8'h00 then 8'hFF, 160 cycles apart.
//   5. reset_n asserted during data bit 3 of 0x5A, released 3 cycles later
//      -> all outputs 0 immediately (async); a subsequent full 0x5A frame gives rx_valid with 8'h5A.
//   6. Default CLKS_PER_BIT=5208, 50 MHz clock, frame 0x47
//      -> rx_data=8'h47; rx_valid about 49_478 cycles after the start edge.

Source files
------------

// File: rtl/uart_rx.sv
// =============================================================================
// uart_rx : UART 8N1 receiver, mid-bit sampling, LSB first, framing-error flag
// Revision: 1.0
// =============================================================================
`default_nettype none

module uart_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxs;

  state_t               r_state, w_state;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt;
  logic [2:0]           r_idx, w_idx;
  logic [7:0]           r_shreg, w_shreg;
  logic [7:0]           r_data, w_data;
  logic                 r_valid, w_valid;
  logic                 r_ferr, w_ferr;

  // Preset to idle-high so a reset never looks like a start edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], RX};
    end
  end

  assign w_rxs = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shreg <= w_shreg;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_ferr  <= w_ferr;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_shreg = r_shreg;
    w_data  = r_data;
    w_valid = 1'b0;
    w_ferr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state = S_START;
          w_cnt   = '0;
        end
      end
      S_START: begin
        // Recheck the line half a bit later to reject glitches
        if (r_cnt == c_HALF) begin
          w_cnt = '0;
          if (w_rxs) begin
            w_state = S_IDLE;
          end else begin
            w_state = S_DATA;
            w_idx   = '0;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == c_LAST) begin
          w_cnt          = '0;
          w_shreg[r_idx] = w_rxs;
          if (r_idx == 3'd7) begin
            w_state = S_STOP;
          end else begin
            w_idx = r_idx + 3'd1;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        // Leaving at mid-stop-bit lets a zero-gap next start bit be seen
        if (r_cnt == c_LAST) begin
          w_cnt = '0;
          if (w_rxs) begin
            w_data  = r_shreg;
            w_valid = 1'b1;
            w_state = S_IDLE;
          end else begin
            w_ferr  = 1'b1;
            w_state = S_BREAK;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_BREAK: begin
        if (w_rxs) begin
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
      end
    endcase
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_frame_err = r_ferr;
  assign rx_busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire
